ttl_counter_pseudoclk: RTL

//  Parametrised synchronous model of the 74x161/163/191 counter family for the ttl_sync library.
//  - All state runs on the single system clock clk.
//  - The chip's own clock pin is the pseudo-clock input tclk; its active edge is found by edge detection.
//  - clr_n acts either asynchronously (74x161 style) or on the tclk edge (74x163 style).
//  - ent/rco cascade like the discrete parts, so several counters can chain into one long counter.

---
 rtl/ttl_counter_pseudoclk.sv | 74 +++++++
 1 files changed

// File: rtl/ttl_counter_pseudoclk.sv
// 74x161/163/191-style counter clocked by clk; tclk edges are detected and act in the same clk cycle.
// q and wrap are registered (one clk after the edge); rco is combinational from q, ent and up.
module ttl_counter_pseudoclk #(
  parameter int             W         = 4,
  parameter int             ASYNC_CLR = 1,
  parameter int             UPDOWN    = 0,
  parameter int             EDGE_POS  = 1,
  parameter logic [W-1:0]   INIT      = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tclk,
  input  logic         clr_n,
  input  logic         load_n,
  input  logic         enp,
  input  logic         ent,
  input  logic         up,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         rco,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic         r_last;
  logic [W-1:0] r_q;
  logic         r_wrap;

  logic         w_act;
  logic         w_down;
  logic         w_tc;
  logic [W-1:0] w_q_nxt;
  logic         w_wrap_nxt;

  assign w_act  = (EDGE_POS != 0) ? (tclk & ~r_last) : (~tclk & r_last);
  assign w_down = (UPDOWN != 0) & ~up;
  assign w_tc   = w_down ? (r_q == '0) : (r_q == '1);

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if ((ASYNC_CLR != 0) && !clr_n) begin
      w_q_nxt = '0;
    end else if (w_act) begin
      if (!clr_n) begin
        w_q_nxt = '0;
      end else if (!load_n) begin
        w_q_nxt = din;
      end else if (enp && ent) begin
        w_q_nxt    = w_down ? (r_q - ONE) : (r_q + ONE);
        w_wrap_nxt = w_tc;
      end
    end
  end

  // last resets to the idle level so the detector starts from a known quiescent state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= (EDGE_POS == 0);
      r_q    <= INIT;
      r_wrap <= 1'b0;
    end else begin
      r_last <= tclk;
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign rco  = ent & w_tc;

endmodule
